// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch program-counter sequencer. Boots to RESET_VEC, then
//               advances by INC or redirects on exception/branch/jump. While
//               fetch is stalled, a redirect is held in a one-entry pending
//               buffer and applied when the stall releases.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_VEC  = '0,
  parameter logic [PC_W-1:0] EXC_VEC    = PC_W'(32'h0000_0080),
  parameter int unsigned     INC        = 4,
  parameter int unsigned     ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallF,
  input  logic            exc,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PC_plus,
  output logic            pc_valid,
  output logic            redirect_pending,
  output logic            misalign
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_br_q, pend_br_d;     // 1 = pending entry is a branch
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

  logic [PC_W-1:0] live_next;
  logic            cap_jmp;

  // Sequential address wraps naturally at 2^PC_W.
  assign PC_plus          = pc_q + PC_W'(INC);
  assign PC               = pc_q;
  assign pc_valid         = (state_q == RUN);
  assign redirect_pending = pend_valid_q;

  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign misalign = |pc_q[ALIGN_BITS-1:0];
    end else begin : g_no_align
      assign misalign = 1'b0;
    end
  endgenerate

  // Live redirect priority and the rule that a jump never displaces a branch.
  always_comb begin
    live_next = PC_plus;
    if (br_taken) begin
      live_next = br_target;
    end else if (jmp) begin
      live_next = jmp_target;
    end
    cap_jmp = jmp && !br_taken && !(pend_valid_q && pend_br_q);
  end

  // Next-state, next-PC and pending-buffer update.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_br_d    = pend_br_q;
    pend_tgt_d   = pend_tgt_q;

    unique case (state_q)
      BOOT: begin
        // All requests are ignored for the one boot cycle.
        state_d      = RUN;
        pc_d         = RESET_VEC;
        pend_valid_d = 1'b0;
      end
      RUN, HOLD: begin
        if (exc) begin
          state_d      = RUN;
          pc_d         = EXC_VEC;
          pend_valid_d = 1'b0;
        end else if (stallF) begin
          state_d = HOLD;
          if (br_taken) begin
            pend_valid_d = 1'b1;
            pend_br_d    = 1'b1;
            pend_tgt_d   = br_target;
          end else if (cap_jmp) begin
            pend_valid_d = 1'b1;
            pend_br_d    = 1'b0;
            pend_tgt_d   = jmp_target;
          end
        end else begin
          // Buffer is always empty in RUN, so this covers both RUN and release.
          state_d      = RUN;
          pc_d         = pend_valid_q ? pend_tgt_q : live_next;
          pend_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = BOOT;
        pc_d         = RESET_VEC;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VEC;
      pend_valid_q <= 1'b0;
      pend_br_q    <= 1'b0;
      pend_tgt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_br_q    <= pend_br_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Each step drives inputs
//               and queues the expected post-edge outputs; the task pops and
//               compares after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallF = 1'b0;
  logic        exc = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_target = '0;
  logic [31:0] PC;
  logic [31:0] PC_plus;
  logic        pc_valid;
  logic        redirect_pending;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        stall;
    logic        exc;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] pc;
    logic        v;
    logic        rp;
    logic        mis;
  } step_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        v;
    logic        rp;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .stallF           (stallF),
    .exc              (exc),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .jmp              (jmp),
    .jmp_target       (jmp_target),
    .PC               (PC),
    .PC_plus          (PC_plus),
    .pc_valid         (pc_valid),
    .redirect_pending (redirect_pending),
    .misalign         (misalign)
  );

  always #5 clk = ~clk;

  function automatic step_t st(logic s, logic e, logic b, logic [31:0] bt,
                               logic j, logic [31:0] jt, logic [31:0] pc,
                               logic v, logic rp, logic mis);
    step_t r;
    r.stall = s; r.exc = e; r.br = b; r.bt = bt; r.jmp = j; r.jt = jt;
    r.pc = pc; r.v = v; r.rp = rp; r.mis = mis;
    return r;
  endfunction

  // Apply one step's inputs and queue what the DUT should show after the edge.
  task automatic drive(input step_t s);
    exp_t e;
    stallF = s.stall; exc = s.exc; br_taken = s.br; br_target = s.bt;
    jmp = s.jmp; jmp_target = s.jt;
    e.pc = s.pc; e.v = s.v; e.rp = s.rp; e.mis = s.mis;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    step_t s[$];
    exp_t  e;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({PC, pc_valid, redirect_pending} !== {32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold: got pc=%h v=%b rp=%b want pc=0 v=0 rp=0", PC, pc_valid, redirect_pending);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({PC, pc_valid} !== {32'h0, 1'b0}) begin
      bad++;
      $display("FAIL boot_state: got pc=%h v=%b want pc=0 v=0", PC, pc_valid);
    end
    s.push_back(st(0,0,0,0,0,0, 32'h0, 1,0,0));
    s.push_back(st(0,0,0,0,0,0, 32'h4, 1,0,0));
    s.push_back(st(0,0,0,0,0,0, 32'h8, 1,0,0));
    s.push_back(st(0,0,0,0,0,0, 32'hC, 1,0,0));
    @(negedge clk);
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({PC, PC_plus, pc_valid, redirect_pending, misalign} !== {e.pc, e.pc + 32'd4, e.v, e.rp, e.mis}) begin
        bad++;
        $display("FAIL boot_seq[%0d]: got pc=%h plus=%h v=%b rp=%b mis=%b want pc=%h plus=%h v=%b rp=%b mis=%b",
                 i, PC, PC_plus, pc_valid, redirect_pending, misalign, e.pc, e.pc + 32'd4, e.v, e.rp, e.mis);
      end
    end
  endtask

  task automatic test_stall_branch();
    step_t s[$];
    exp_t  e;
    s.push_back(st(0,0,0,0,            0,0, 32'h10, 1,0,0));
    s.push_back(st(1,0,1,32'h40,       0,0, 32'h10, 0,1,0));
    s.push_back(st(1,0,0,0,            0,0, 32'h10, 0,1,0));
    s.push_back(st(0,0,0,0,            0,0, 32'h40, 1,0,0));
    s.push_back(st(0,0,0,0,            0,0, 32'h44, 1,0,0));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({PC, PC_plus, pc_valid, redirect_pending, misalign} !== {e.pc, e.pc + 32'd4, e.v, e.rp, e.mis}) begin
        bad++;
        $display("FAIL stall_branch[%0d]: got pc=%h plus=%h v=%b rp=%b mis=%b want pc=%h plus=%h v=%b rp=%b mis=%b",
                 i, PC, PC_plus, pc_valid, redirect_pending, misalign, e.pc, e.pc + 32'd4, e.v, e.rp, e.mis);
      end
    end
  endtask

  task automatic test_pending_priority();
    step_t s[$];
    exp_t  e;
    // jump, then branch overwrites, then jump ignored; pending beats live jump
    s.push_back(st(1,0,0,0,        1,32'h200, 32'h44,  0,1,0));
    s.push_back(st(1,0,1,32'h300,  0,0,       32'h44,  0,1,0));
    s.push_back(st(1,0,0,0,        1,32'h400, 32'h44,  0,1,0));
    s.push_back(st(0,0,0,0,        1,32'h500, 32'h300, 1,0,0));
    s.push_back(st(0,0,0,0,        0,0,       32'h304, 1,0,0));
    // empty buffer at release: live branch beats live jump
    s.push_back(st(1,0,0,0,        0,0,       32'h304, 0,0,0));
    s.push_back(st(0,0,1,32'h600,  1,32'h700, 32'h600, 1,0,0));
    // pending jump alone is taken
    s.push_back(st(1,0,0,0,        1,32'h200, 32'h600, 0,1,0));
    s.push_back(st(0,0,0,0,        0,0,       32'h200, 1,0,0));
    // later branch overwrites earlier branch
    s.push_back(st(1,0,1,32'h800,  0,0,       32'h200, 0,1,0));
    s.push_back(st(1,0,1,32'h900,  0,0,       32'h200, 0,1,0));
    s.push_back(st(0,0,0,0,        0,0,       32'h900, 1,0,0));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({PC, PC_plus, pc_valid, redirect_pending, misalign} !== {e.pc, e.pc + 32'd4, e.v, e.rp, e.mis}) begin
        bad++;
        $display("FAIL pending_prio[%0d]: got pc=%h plus=%h v=%b rp=%b mis=%b want pc=%h plus=%h v=%b rp=%b mis=%b",
                 i, PC, PC_plus, pc_valid, redirect_pending, misalign, e.pc, e.pc + 32'd4, e.v, e.rp, e.mis);
      end
    end
  endtask

  task automatic test_exc();
    step_t s[$];
    exp_t  e;
    s.push_back(st(1,0,1,32'h40, 0,0,       32'h900, 0,1,0));
    s.push_back(st(1,1,0,0,      0,0,       32'h80,  1,0,0));
    s.push_back(st(0,0,0,0,      0,0,       32'h84,  1,0,0));
    s.push_back(st(0,1,1,32'h20, 1,32'h30,  32'h80,  1,0,0));
    s.push_back(st(0,0,1,32'h20, 1,32'h30,  32'h20,  1,0,0));
    s.push_back(st(0,0,0,0,      1,32'h30,  32'h30,  1,0,0));
    s.push_back(st(1,1,1,32'h20, 0,0,       32'h80,  1,0,0));
    s.push_back(st(0,0,0,0,      0,0,       32'h84,  1,0,0));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({PC, PC_plus, pc_valid, redirect_pending, misalign} !== {e.pc, e.pc + 32'd4, e.v, e.rp, e.mis}) begin
        bad++;
        $display("FAIL exc[%0d]: got pc=%h plus=%h v=%b rp=%b mis=%b want pc=%h plus=%h v=%b rp=%b mis=%b",
                 i, PC, PC_plus, pc_valid, redirect_pending, misalign, e.pc, e.pc + 32'd4, e.v, e.rp, e.mis);
      end
    end
  endtask

  task automatic test_wrap_misalign();
    step_t s[$];
    exp_t  e;
    s.push_back(st(0,0,0,0,        1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,0,0));
    s.push_back(st(0,0,0,0,        0,0,             32'h0,         1,0,0));
    s.push_back(st(0,0,1,32'h102,  0,0,             32'h102,       1,0,1));
    s.push_back(st(0,0,0,0,        0,0,             32'h106,       1,0,1));
    s.push_back(st(0,0,0,0,        1,32'h101,       32'h101,       1,0,1));
    s.push_back(st(0,0,0,0,        0,0,             32'h105,       1,0,1));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({PC, PC_plus, pc_valid, redirect_pending, misalign} !== {e.pc, e.pc + 32'd4, e.v, e.rp, e.mis}) begin
        bad++;
        $display("FAIL wrap_mis[%0d]: got pc=%h plus=%h v=%b rp=%b mis=%b want pc=%h plus=%h v=%b rp=%b mis=%b",
                 i, PC, PC_plus, pc_valid, redirect_pending, misalign, e.pc, e.pc + 32'd4, e.v, e.rp, e.mis);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    step_t s[$];
    exp_t  e;
    drive(st(1,0,1,32'h40, 0,0, 32'h105, 0,1,1));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if ({PC, pc_valid, redirect_pending, misalign} !== {e.pc, e.v, e.rp, e.mis}) begin
      bad++;
      $display("FAIL mid_hold_setup: got pc=%h v=%b rp=%b mis=%b want pc=%h v=%b rp=%b mis=%b",
               PC, pc_valid, redirect_pending, misalign, e.pc, e.v, e.rp, e.mis);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({PC, pc_valid, redirect_pending, misalign} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got pc=%h v=%b rp=%b mis=%b want pc=0 v=0 rp=0 mis=0",
               PC, pc_valid, redirect_pending, misalign);
    end
    exc = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({PC, pc_valid, redirect_pending} !== {32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_held: got pc=%h v=%b rp=%b want pc=0 v=0 rp=0", PC, pc_valid, redirect_pending);
    end
    rst = 1'b1;
    // boot edge ignores every request
    s.push_back(st(1,1,1,32'h40, 1,32'h50, 32'h0, 1,0,0));
    s.push_back(st(0,0,0,0,      0,0,      32'h4, 1,0,0));
    s.push_back(st(0,0,0,0,      0,0,      32'h8, 1,0,0));
    s.push_back(st(0,0,0,0,      0,0,      32'hC, 1,0,0));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({PC, PC_plus, pc_valid, redirect_pending, misalign} !== {e.pc, e.pc + 32'd4, e.v, e.rp, e.mis}) begin
        bad++;
        $display("FAIL reboot[%0d]: got pc=%h plus=%h v=%b rp=%b mis=%b want pc=%h plus=%h v=%b rp=%b mis=%b",
                 i, PC, PC_plus, pc_valid, redirect_pending, misalign, e.pc, e.pc + 32'd4, e.v, e.rp, e.mis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall_branch();
    test_pending_priority();
    test_exc();
    test_wrap_misalign();
    test_reset_mid_hold();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL provide parameter PC_W, default 32, PC and target width in bits.
REQ-002 SHALL provide parameter RESET_VEC, default 0 (PC_W bits), PC value loaded by reset.
REQ-003 SHALL provide parameter EXC_VEC, default 32'h0000_0080 (PC_W bits), exception redirect address.
REQ-004 SHALL provide parameter INC, default 4, sequential increment.
REQ-005 SHALL provide parameter ALIGN_BITS, default 2, low PC bits that must be zero.
REQ-006 SHALL provide port clk, input, 1, rising-edge clock.
REQ-007 SHALL provide port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL provide port stallF, input, 1, fetch stall: hold PC.
REQ-009 SHALL provide port exc, input, 1, exception request.
REQ-010 SHALL provide port br_taken, input, 1, branch redirect request.
REQ-011 SHALL provide port br_target, input, PC_W, branch target.
REQ-012 SHALL provide port jmp, input, 1, jump redirect request.
REQ-013 SHALL provide port jmp_target, input, PC_W, jump target.
REQ-014 SHALL provide port PC, output, PC_W, current fetch address.
REQ-015 SHALL provide port PC_plus, output, PC_W, combinational PC+INC mod 2^PC_W.
REQ-016 SHALL provide port pc_valid, output, 1, PC is a live fetch address this cycle.
REQ-017 SHALL provide port redirect_pending, output, 1, a redirect is buffered during stall.
REQ-018 SHALL provide port misalign, output, 1, PC[ALIGN_BITS-1:0] != 0 (combinational).

Function
REQ-019 SHALL implement FSM states BOOT, RUN, HOLD, all updates on rising clk.
REQ-020 SHALL leave BOOT for RUN after exactly one clock edge, PC held at RESET_VEC, pc_valid=0.
REQ-021 SHALL, in RUN with stallF=0, load next PC by priority: exc -> EXC_VEC; br_taken -> br_target; jmp -> jmp_target; else PC_plus.
REQ-022 SHALL compute sequential PC modulo 2^PC_W: PC = 2^PC_W-INC yields 0, no flag.
REQ-023 SHALL, in RUN with stallF=1 and no exc, hold PC and enter HOLD; any br_taken/jmp that cycle is captured into the pending buffer.
REQ-024 SHALL, in HOLD, keep PC unchanged and pc_valid=0.
REQ-025 SHALL, in HOLD, capture br_taken/jmp into the pending buffer (target + kind); a branch overwrites a pending jump; a jump never overwrites a pending branch; a later branch overwrites an earlier branch.
REQ-026 SHALL drive redirect_pending=1 from the cycle after capture until the buffer is consumed or cleared.
REQ-027 SHALL, on stallF falling in HOLD (no exc), load pending target if valid, else live br_taken/jmp/PC_plus per REQ-021; clear the buffer; enter RUN.
REQ-028 SHALL treat pending over live redirect in the release cycle: pending > br_taken > jmp > PC_plus.
REQ-029 SHALL let exc override stallF in any state except BOOT: PC <= EXC_VEC next edge, pending buffer cleared, state RUN.
REQ-030 SHALL ignore exc, br_taken, jmp, stallF while in BOOT.
REQ-031 SHALL load redirect targets unmodified; misalign reflects the resulting PC, no trap generated here.
REQ-032 SHALL drive pc_valid=1 only in RUN.

Reset
REQ-033 SHALL, on rst=0 at any time, asynchronously force PC=RESET_VEC, state BOOT, pending buffer empty, redirect_pending=0, pc_valid=0.
REQ-034 SHALL discard any stall or pending redirect in progress on reset mid-operation.
REQ-035 SHALL resume per REQ-020 on the first rising edge after rst returns to 1.

Verification
REQ-036 Reset release, no stall/redirect, 4 edges -> PC: 0 (BOOT), 0, 4, 8, 12; pc_valid 0,1,1,1,1.
REQ-037 RUN at PC=0x10, stallF=1 two cycles with br_taken=1 target 0x40 in first stall cycle, then stallF=0 -> PC holds 0x10, redirect_pending=1, then PC=0x40, redirect_pending=0.
REQ-038 HOLD with pending jump 0x200 then branch 0x300, then jump 0x400; release -> PC=0x300.
REQ-039 HOLD with pending branch 0x40, exc=1 while stallF=1 -> next PC=0x80, redirect_pending=0, pc_valid=1.
REQ-040 PC=0xFFFF_FFFC, no stall -> next PC=0x0; br_target 0x102 -> PC=0x102, misalign=1.
REQ-041 rst=0 asserted mid-HOLD with pending redirect -> PC=0 immediately (no clock), redirect_pending=0; release -> REQ-036 sequence.
